// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: widths, FSM state encoding and
// the register-zero address.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // State entered when an instruction is accepted.
  function automatic wb_state_t accept_target(input logic r_en);
    return r_en ? WAIT_MEM : WRITE;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake plus the register-file write port and retire/debug outputs.
// master = MEM stage / consumers side, slave = wb_stage.
interface wb_stage_if
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
);
  logic          MEM_valid;
  logic          MEM_ready;
  logic          MEM_WB_EN;
  logic          MEM_R_EN;
  logic [AW-1:0] MEM_Dest;
  logic [DW-1:0] ALU_Result;
  logic [DW-1:0] Mem_Data;
  logic          Mem_Data_Valid;
  logic          WB_Write_Enable;
  logic [AW-1:0] WB_Dest;
  logic [DW-1:0] WB_Data;
  logic          WB_Busy;
  logic          Retired;
  logic [31:0]   Retire_Count;

  modport master (
    output MEM_valid, MEM_WB_EN, MEM_R_EN, MEM_Dest, ALU_Result,
           Mem_Data, Mem_Data_Valid,
    input  MEM_ready, WB_Write_Enable, WB_Dest, WB_Data, WB_Busy,
           Retired, Retire_Count
  );

  modport slave (
    input  MEM_valid, MEM_WB_EN, MEM_R_EN, MEM_Dest, ALU_Result,
           Mem_Data, Mem_Data_Valid,
    output MEM_ready, WB_Write_Enable, WB_Dest, WB_Data, WB_Busy,
           Retired, Retire_Count
  );
endinterface

// File: rtl/wb_stage_mem_wb_reg.sv
// Capture register for the retiring instruction. The data field can be
// overwritten on its own when load data comes back from memory.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              wb_en_d,
  input  logic              r_en_d,
  input  logic [REG_AW-1:0] dest_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic              data_load,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_en_q,
  output logic              r_en_q,
  output logic [REG_AW-1:0] dest_q,
  output logic [DATA_W-1:0] data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      r_en_q  <= 1'b0;
      dest_q  <= '0;
    end else if (load) begin
      wb_en_q <= wb_en_d;
      r_en_q  <= r_en_d;
      dest_q  <= dest_d;
    end
  end

  // A new instruction always wins over a memory return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data_d;
    end else if (data_load) begin
      data_q <= mem_data;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one instruction at a time, waits for load data,
// drives the register-file write port and counts retirements.
//
//   state    | meaning
//   IDLE     | nothing held, ready for an instruction
//   WAIT_MEM | load held, waiting for Mem_Data_Valid
//   WRITE    | held instruction retires this cycle; may accept the next one
module wb_stage
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  wb_state_t         state_q, state_d;
  logic              accept;
  logic              data_load;
  logic              wb_en_q, r_en_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       retire_count_q;

  assign bus.MEM_ready = (state_q != WAIT_MEM);
  assign accept        = bus.MEM_valid & bus.MEM_ready;
  assign data_load     = (state_q == WAIT_MEM) & r_en_q & bus.Mem_Data_Valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = accept_target(bus.MEM_R_EN);
      end
      WAIT_MEM: begin
        if (data_load) state_d = WRITE;
      end
      WRITE: begin
        if (accept) state_d = accept_target(bus.MEM_R_EN);
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .wb_en_d   (bus.MEM_WB_EN),
    .r_en_d    (bus.MEM_R_EN),
    .dest_d    (bus.MEM_Dest),
    .data_d    (bus.ALU_Result),
    .data_load (data_load),
    .mem_data  (bus.Mem_Data),
    .wb_en_q   (wb_en_q),
    .r_en_q    (r_en_q),
    .dest_q    (dest_q),
    .data_q    (data_q)
  );

  // Counted on entry to WRITE so the count already includes the instruction
  // retiring in the current cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  retire_count_q <= '0;
    else if (state_d == WRITE) retire_count_q <= retire_count_q + 32'd1;
  end

  assign bus.WB_Write_Enable = (state_q == WRITE) & wb_en_q & (dest_q != REG_ZERO);
  assign bus.WB_Dest         = dest_q;
  assign bus.WB_Data         = data_q;
  assign bus.WB_Busy         = (state_q != IDLE);
  assign bus.Retired         = (state_q == WRITE);
  assign bus.Retire_Count    = retire_count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected writes are queued when stimulus is
// driven and popped by a monitor whenever the stage retires an instruction.
module tb_wb_stage;
  import mips_pkg::*;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  logic [31:0] exp_count = 32'd0;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every retirement must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.WB_Write_Enable && !bus.Retired) begin
        n_total++;
        $display("FAIL strobe_without_retire: WB_Write_Enable=1 while Retired=0");
      end
      if (bus.Retired) begin
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_retire: dest=%0d data=%h with empty scoreboard",
                   bus.WB_Dest, bus.WB_Data);
        end else begin
          e = sb.pop_front();
          exp_count = exp_count + 32'd1;
          if (bus.WB_Write_Enable !== e.we || bus.WB_Dest !== e.dest ||
              bus.WB_Data !== e.data || bus.Retire_Count !== exp_count) begin
            $display("FAIL retire: got we=%b dest=%0d data=%h cnt=%h, expected we=%b dest=%0d data=%h cnt=%h",
                     bus.WB_Write_Enable, bus.WB_Dest, bus.WB_Data, bus.Retire_Count,
                     e.we, e.dest, e.data, exp_count);
          end else begin
            n_pass++;
          end
        end
      end
    end
  end

  task automatic push_exp(input logic we, input logic [4:0] dest, input logic [31:0] data);
    exp_t e;
    e.we = we; e.dest = dest; e.data = data;
    sb.push_back(e);
  endtask

  // Presents one instruction for a single cycle; called just after a rising edge.
  task automatic drive_instr(input logic wb_en, input logic r_en,
                             input logic [4:0] dest, input logic [31:0] alu);
    bus.MEM_valid  = 1'b1;
    bus.MEM_WB_EN  = wb_en;
    bus.MEM_R_EN   = r_en;
    bus.MEM_Dest   = dest;
    bus.ALU_Result = alu;
    @(posedge clk); #1;
    bus.MEM_valid  = 1'b0;
    bus.MEM_WB_EN  = 1'b0;
    bus.MEM_R_EN   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_total++;
    if (bus.WB_Write_Enable !== 1'b0 || bus.WB_Dest !== 5'd0 || bus.WB_Data !== 32'd0 ||
        bus.Retired !== 1'b0 || bus.WB_Busy !== 1'b0 || bus.MEM_ready !== 1'b1 ||
        bus.Retire_Count !== 32'd0) begin
      $display("FAIL reset_values: we=%b dest=%0d data=%h ret=%b busy=%b ready=%b cnt=%h, expected all 0 with ready=1",
               bus.WB_Write_Enable, bus.WB_Dest, bus.WB_Data, bus.Retired,
               bus.WB_Busy, bus.MEM_ready, bus.Retire_Count);
    end else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1);

    // Load to r3 abandoned by a reset while waiting for memory.
    drive_instr(1'b1, 1'b1, 5'd3, 32'h0000_0033);
    @(negedge clk);
    n_total++;
    if (bus.MEM_ready !== 1'b0 || bus.WB_Busy !== 1'b1) begin
      $display("FAIL wait_mem_before_reset: ready=%b busy=%b, expected 0/1", bus.MEM_ready, bus.WB_Busy);
    end else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (bus.MEM_ready !== 1'b1 || bus.Retire_Count !== 32'd0 || bus.WB_Busy !== 1'b0) begin
      $display("FAIL reset_mid_wait: ready=%b cnt=%h busy=%b, expected 1/0/0",
               bus.MEM_ready, bus.Retire_Count, bus.WB_Busy);
    end else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 32'd0;
    // Late memory return must not resurrect the abandoned load.
    bus.Mem_Data = 32'hAAAA_5555;
    bus.Mem_Data_Valid = 1'b1;
    idle_cycles(2);
    bus.Mem_Data_Valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.Retire_Count !== 32'd0 || bus.WB_Busy !== 1'b0) begin
      $display("FAIL no_retire_after_reset: cnt=%h busy=%b, expected 0/0", bus.Retire_Count, bus.WB_Busy);
    end else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    push_exp(1'b1, 5'd5, 32'h0000_002A);
    drive_instr(1'b1, 1'b0, 5'd5, 32'h0000_002A);
    @(negedge clk);
    n_total++;
    if (bus.WB_Write_Enable !== 1'b1 || bus.Retired !== 1'b1 || bus.Retire_Count !== 32'd1) begin
      $display("FAIL add_strobe: we=%b ret=%b cnt=%h, expected 1/1/1",
               bus.WB_Write_Enable, bus.Retired, bus.Retire_Count);
    end else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (bus.WB_Write_Enable !== 1'b0 || bus.WB_Busy !== 1'b0) begin
      $display("FAIL add_single_cycle: we=%b busy=%b, expected 0/0", bus.WB_Write_Enable, bus.WB_Busy);
    end else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    // Valid coinciding with the accept edge must be ignored.
    bus.Mem_Data = 32'h0BAD_0BAD;
    bus.Mem_Data_Valid = 1'b1;
    drive_instr(1'b1, 1'b1, 5'd7, 32'h1111_1111);
    bus.Mem_Data_Valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        bus.Mem_Data = 32'hDEAD_BEEF;
        bus.Mem_Data_Valid = 1'b1;
        push_exp(1'b1, 5'd7, 32'hDEAD_BEEF);
      end
      @(negedge clk);
      n_total++;
      if (bus.MEM_ready !== 1'b0 || bus.Retired !== 1'b0) begin
        $display("FAIL load_wait_t%0d: ready=%b ret=%b, expected 0/0", k, bus.MEM_ready, bus.Retired);
      end else n_pass++;
      @(posedge clk); #1;
    end
    bus.Mem_Data_Valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.WB_Write_Enable !== 1'b1 || bus.WB_Data !== 32'hDEAD_BEEF || bus.MEM_ready !== 1'b1) begin
      $display("FAIL load_write: we=%b data=%h ready=%b, expected 1/deadbeef/1",
               bus.WB_Write_Enable, bus.WB_Data, bus.MEM_ready);
    end else n_pass++;
    @(posedge clk); #1;

    // Load without a register write still waits for memory.
    drive_instr(1'b0, 1'b1, 5'd9, 32'h0);
    idle_cycles(1);
    @(negedge clk);
    n_total++;
    if (bus.WB_Busy !== 1'b1 || bus.Retired !== 1'b0) begin
      $display("FAIL load_nowb_waits: busy=%b ret=%b, expected 1/0", bus.WB_Busy, bus.Retired);
    end else n_pass++;
    @(posedge clk); #1;
    bus.Mem_Data = 32'h1234_5678;
    bus.Mem_Data_Valid = 1'b1;
    push_exp(1'b0, 5'd9, 32'h1234_5678);
    @(posedge clk); #1;
    bus.Mem_Data_Valid = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_r0_and_store;
    push_exp(1'b0, 5'd0, 32'h0000_0055);
    drive_instr(1'b1, 1'b0, 5'd0, 32'h0000_0055);
    @(negedge clk);
    n_total++;
    if (bus.WB_Write_Enable !== 1'b0 || bus.Retired !== 1'b1) begin
      $display("FAIL write_r0: we=%b ret=%b, expected 0/1", bus.WB_Write_Enable, bus.Retired);
    end else n_pass++;
    @(posedge clk); #1;
    push_exp(1'b0, 5'd12, 32'hCAFE_0001);
    drive_instr(1'b0, 1'b0, 5'd12, 32'hCAFE_0001);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] base;
    base = exp_count;
    bus.Mem_Data = 32'hFFFF_0000;
    bus.Mem_Data_Valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.MEM_valid  = 1'b1;
      bus.MEM_WB_EN  = 1'b1;
      bus.MEM_R_EN   = 1'b0;
      bus.MEM_Dest   = 5'(i);
      bus.ALU_Result = 32'h100 + 32'(i);
      push_exp(1'b1, 5'(i), 32'h100 + 32'(i));
      @(negedge clk);
      if (i > 1) begin
        n_total++;
        if (bus.Retired !== 1'b1 || bus.MEM_ready !== 1'b1) begin
          $display("FAIL b2b_cycle_%0d: ret=%b ready=%b, expected 1/1", i, bus.Retired, bus.MEM_ready);
        end else n_pass++;
      end
      @(posedge clk); #1;
    end
    bus.MEM_valid = 1'b0;
    bus.Mem_Data_Valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.Retired !== 1'b1 || bus.Retire_Count !== base + 32'd4) begin
      $display("FAIL b2b_count: ret=%b cnt=%h, expected 1/%h", bus.Retired, bus.Retire_Count, base + 32'd4);
    end else n_pass++;
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.retire_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_count_q;
    exp_count = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    push_exp(1'b1, 5'd20, 32'h0000_0020);
    push_exp(1'b1, 5'd21, 32'h0000_0021);
    drive_instr(1'b1, 1'b0, 5'd20, 32'h0000_0020);
    @(negedge clk);
    n_total++;
    if (bus.Retire_Count !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_max: cnt=%h, expected ffffffff", bus.Retire_Count);
    end else n_pass++;
    @(posedge clk); #1;
    drive_instr(1'b1, 1'b0, 5'd21, 32'h0000_0021);
    @(negedge clk);
    n_total++;
    if (bus.Retire_Count !== 32'd0) begin
      $display("FAIL wrap_zero: cnt=%h, expected 0", bus.Retire_Count);
    end else n_pass++;
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  initial begin
    bus.MEM_valid      = 1'b0;
    bus.MEM_WB_EN      = 1'b0;
    bus.MEM_R_EN       = 1'b0;
    bus.MEM_Dest       = 5'd0;
    bus.ALU_Result     = 32'd0;
    bus.Mem_Data       = 32'd0;
    bus.Mem_Data_Valid = 1'b0;
    #1;
    test_reset();
    test_add();
    test_load();
    test_r0_and_store();
    test_back_to_back();
    test_wrap();
    n_total++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drained: %0d expected retirements never seen", sb.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
